// File: rtl/corner_scan_ctrl.sv
// rtl/corner_scan_ctrl.sv - frame scan controller that tracks corner detections in raster order
//
// Purpose: walks one H_ACTIVE x V_ACTIVE frame per accepted start, gates the
// external corner detector, aligns its delayed results with the pixel
// coordinates, and reports first-corner position and detection count.
//
// Ports:
//   clk, reset                  sole clock, synchronous active-high reset
//   start                       one-cycle frame request (honoured only in IDLE)
//   pixel_valid                 upstream pixel present this cycle
//   corner_detected             detector result, DET_LAT cycles after its pixel
//   det_enable                  high in SCAN, gates pixel_valid into the detector
//   x, y                        coordinates of the pixel accepted this cycle
//   corner_x, corner_y          first counted detection of the frame (3FF = none)
//   corner_count                detections this frame, saturating at 255
//   busy, done                  busy in SCAN/DRAIN, done one-cycle pulse in DONE
//   bbox_xmin/xmax/ymin/ymax    bounding box of detections (CORNER_BBOX_EN only)
//
// Configuration: define CORNER_BBOX_EN to add the bounding-box outputs.

module corner_scan_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int DET_LAT  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pixel_valid,
  input  logic       corner_detected,
  output logic       det_enable,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic [9:0] corner_x,
  output logic [9:0] corner_y,
  output logic [7:0] corner_count,
  output logic       busy,
  output logic       done
`ifdef CORNER_BBOX_EN
  ,
  output logic [9:0] bbox_xmin,
  output logic [9:0] bbox_xmax,
  output logic [9:0] bbox_ymin,
  output logic [9:0] bbox_ymax
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;

  state_t     state;
  state_t     state_next;
  logic [2:0] drain_cnt;

  // Pipeline that mirrors the detector latency so each result meets its pixel.
  logic [9:0] dly_x   [DET_LAT];
  logic [9:0] dly_y   [DET_LAT];
  logic       dly_acc [DET_LAT];

  logic start_ok;
  logic accept;
  logic last_pix;
  logic hit;

  assign start_ok = (state == S_IDLE) && start;
  assign accept   = (state == S_SCAN) && pixel_valid;
  assign last_pix = (x == 10'(H_ACTIVE - 1)) && (y == 10'(V_ACTIVE - 1));
  // Detections lining up with a non-accepted slot are stale or spurious.
  assign hit      = corner_detected && dly_acc[DET_LAT-1];

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_SCAN;
      S_SCAN:  if (accept && last_pix) state_next = S_DRAIN;
      S_DRAIN: if (drain_cnt == 3'(DET_LAT - 1)) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    det_enable = (state == S_SCAN);
    busy       = (state == S_SCAN) || (state == S_DRAIN);
    done       = (state == S_DONE);
  end

  // DRAIN timer runs on cycles, not on pixel_valid, so gaps cannot stretch it.
  always_ff @(posedge clk) begin
    if (reset || state != S_DRAIN) begin
      drain_cnt <= 3'd0;
    end else begin
      drain_cnt <= drain_cnt + 3'd1;
    end
  end

  // Datapath: coordinates, delay line, and result registers
  always_ff @(posedge clk) begin
    if (reset || start_ok) begin
      x            <= 10'd0;
      y            <= 10'd0;
      corner_x     <= 10'h3FF;
      corner_y     <= 10'h3FF;
      corner_count <= 8'd0;
      for (int i = 0; i < DET_LAT; i++) begin
        dly_x[i]   <= 10'd0;
        dly_y[i]   <= 10'd0;
        dly_acc[i] <= 1'b0;
      end
`ifdef CORNER_BBOX_EN
      bbox_xmin <= 10'h3FF;
      bbox_xmax <= 10'd0;
      bbox_ymin <= 10'h3FF;
      bbox_ymax <= 10'd0;
`endif
    end else begin
      dly_x[0]   <= x;
      dly_y[0]   <= y;
      dly_acc[0] <= accept;
      for (int i = 1; i < DET_LAT; i++) begin
        dly_x[i]   <= dly_x[i-1];
        dly_y[i]   <= dly_y[i-1];
        dly_acc[i] <= dly_acc[i-1];
      end

      if (accept) begin
        if (x == 10'(H_ACTIVE - 1)) begin
          x <= 10'd0;
          y <= last_pix ? 10'd0 : y + 10'd1;
        end else begin
          x <= x + 10'd1;
        end
      end

      if (hit) begin
        // Count only returns to zero on start/reset, so zero marks "no corner yet".
        if (corner_count == 8'd0) begin
          corner_x <= dly_x[DET_LAT-1];
          corner_y <= dly_y[DET_LAT-1];
        end
        if (corner_count != 8'hFF) begin
          corner_count <= corner_count + 8'd1;
        end
`ifdef CORNER_BBOX_EN
        if (dly_x[DET_LAT-1] < bbox_xmin) bbox_xmin <= dly_x[DET_LAT-1];
        if (dly_x[DET_LAT-1] > bbox_xmax) bbox_xmax <= dly_x[DET_LAT-1];
        if (dly_y[DET_LAT-1] < bbox_ymin) bbox_ymin <= dly_y[DET_LAT-1];
        if (dly_y[DET_LAT-1] > bbox_ymax) bbox_ymax <= dly_y[DET_LAT-1];
`endif
      end
    end
  end

endmodule

// File: tb/tb_corner_scan_ctrl.sv
// tb/tb_corner_scan_ctrl.sv - self-checking bench for corner_scan_ctrl
module tb_corner_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, pixel_valid, corner_detected;
  logic       det_enable, busy, done;
  logic [9:0] x, y, corner_x, corner_y;
  logic [7:0] corner_count;

  logic       start2, pixel_valid2, corner_detected2;
  logic       det_enable2, busy2, done2;
  logic [9:0] x2, y2, corner_x2, corner_y2;
  logic [7:0] corner_count2;

`ifdef CORNER_BBOX_EN
  logic [9:0] bxmin, bxmax, bymin, bymax;
  logic [9:0] bxmin2, bxmax2, bymin2, bymax2;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  corner_scan_ctrl #(.H_ACTIVE(4), .V_ACTIVE(2), .DET_LAT(2)) dut (
    .clk(clk), .reset(reset), .start(start), .pixel_valid(pixel_valid),
    .corner_detected(corner_detected), .det_enable(det_enable), .x(x), .y(y),
    .corner_x(corner_x), .corner_y(corner_y), .corner_count(corner_count),
    .busy(busy), .done(done)
`ifdef CORNER_BBOX_EN
    , .bbox_xmin(bxmin), .bbox_xmax(bxmax), .bbox_ymin(bymin), .bbox_ymax(bymax)
`endif
  );

  corner_scan_ctrl #(.H_ACTIVE(20), .V_ACTIVE(15), .DET_LAT(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .pixel_valid(pixel_valid2),
    .corner_detected(corner_detected2), .det_enable(det_enable2), .x(x2), .y(y2),
    .corner_x(corner_x2), .corner_y(corner_y2), .corner_count(corner_count2),
    .busy(busy2), .done(done2)
`ifdef CORNER_BBOX_EN
    , .bbox_xmin(bxmin2), .bbox_xmax(bxmax2), .bbox_ymin(bymin2), .bbox_ymax(bymax2)
`endif
  );

  typedef struct {
    string      name;
    logic [7:0] mask;     // bit i: detector fires for pixel index i (raster order)
    logic       spur;     // detector fires while delayed accepted bit is 0
    int         exp_cnt;
    logic [9:0] exp_cx;
    logic [9:0] exp_cy;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start at cycle 0, pixels back-to-back in cycles 1..8, detections 2 cycles later.
  task automatic run_frame(input string name, input logic [7:0] mask, input logic spur,
                           input int exp_cnt, input logic [9:0] exp_cx, input logic [9:0] exp_cy);
    for (int c = 0; c <= 13; c++) begin
      start           = (c == 0);
      pixel_valid     = (c >= 1 && c <= 8);
      corner_detected = (c >= 3 && c <= 10) ? mask[c-3] : 1'b0;
      if (c == 2 && spur) corner_detected = 1'b1;
      @(negedge clk);
      if (c == 1) begin
        chk({name, " busy"}, 32'(busy), 32'd1);
        chk({name, " x0"}, 32'(x), 32'd0);
        chk({name, " y0"}, 32'(y), 32'd0);
      end
      if (c == 10) chk({name, " done early"}, 32'(done), 32'd0);
      if (c == 11) begin
        chk({name, " done"}, 32'(done), 32'd1);
        chk({name, " count"}, 32'(corner_count), 32'(exp_cnt));
        chk({name, " corner_x"}, 32'(corner_x), 32'(exp_cx));
        chk({name, " corner_y"}, 32'(corner_y), 32'(exp_cy));
      end
      if (c == 12) begin
        chk({name, " done late"}, 32'(done), 32'd0);
        chk({name, " count hold"}, 32'(corner_count), 32'(exp_cnt));
      end
      tick();
    end
    start = 1'b0; pixel_valid = 1'b0; corner_detected = 1'b0;
  endtask

  initial begin
    int ndone;
    int done_at;

    vecs[0] = '{"none",    8'b0000_0000, 1'b0, 0, 10'h3FF, 10'h3FF};
    vecs[1] = '{"two",     8'b0100_0010, 1'b0, 2, 10'd1,   10'd0};
    vecs[2] = '{"final",   8'b1000_0000, 1'b0, 1, 10'd3,   10'd1};
    vecs[3] = '{"spurious",8'b0000_0000, 1'b1, 0, 10'h3FF, 10'h3FF};
    vecs[4] = '{"all",     8'b1111_1111, 1'b0, 8, 10'd0,   10'd0};
    vecs[5] = '{"row1",    8'b0011_0000, 1'b1, 2, 10'd0,   10'd1};

    reset = 1'b1; start = 1'b0; pixel_valid = 1'b0; corner_detected = 1'b0;
    start2 = 1'b0; pixel_valid2 = 1'b0; corner_detected2 = 1'b0;
    tick(); tick(); tick();
    @(negedge clk);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst det_enable", 32'(det_enable), 32'd0);
    chk("rst x", 32'(x), 32'd0);
    chk("rst y", 32'(y), 32'd0);
    chk("rst count", 32'(corner_count), 32'd0);
    chk("rst corner_x", 32'(corner_x), 32'h3FF);
    chk("rst corner_y", 32'(corner_y), 32'h3FF);
    reset = 1'b0;
    tick();

    for (int v = 0; v < 6; v++) begin
      run_frame(vecs[v].name, vecs[v].mask, vecs[v].spur, vecs[v].exp_cnt,
                vecs[v].exp_cx, vecs[v].exp_cy);
`ifdef CORNER_BBOX_EN
      if (v == 1) begin
        chk("bbox xmin", 32'(bxmin), 32'd1);
        chk("bbox xmax", 32'(bxmax), 32'd2);
        chk("bbox ymin", 32'(bymin), 32'd0);
        chk("bbox ymax", 32'(bymax), 32'd1);
      end
`endif
    end

    // Reset mid-SCAN while pixel 5 is presented.
    for (int c = 0; c <= 6; c++) begin
      start = (c == 0);
      pixel_valid = (c >= 1);
      corner_detected = (c == 4);
      reset = (c == 6);
      tick();
    end
    reset = 1'b0; pixel_valid = 1'b0; corner_detected = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst det_enable", 32'(det_enable), 32'd0);
    chk("midrst count", 32'(corner_count), 32'd0);
    chk("midrst x", 32'(x), 32'd0);
    chk("midrst corner_x", 32'(corner_x), 32'h3FF);
    tick();

    // Reset wins over start in the same cycle.
    reset = 1'b1; start = 1'b1;
    tick();
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst_vs_start busy", 32'(busy), 32'd0);
    tick();
    run_frame("rescan", 8'b0000_0100, 1'b0, 1, 10'd2, 10'd0);

    // Start re-pulsed in SCAN/DRAIN/DONE, pixel_valid toggling.
    ndone = 0;
    for (int c = 0; c <= 24; c++) begin
      start = (c == 0 || c == 4 || c == 17 || c == 18);
      pixel_valid = (c % 2 == 1) && (c <= 15);
      corner_detected = 1'b0;
      @(negedge clk);
      if (c % 2 == 1 && c <= 15) begin
        chk($sformatf("gap x c%0d", c), 32'(x), 32'(((c - 1) / 2) % 4));
        chk($sformatf("gap y c%0d", c), 32'(y), 32'(((c - 1) / 2) / 4));
      end
      if (done) ndone++;
      if (c == 18) chk("gap done", 32'(done), 32'd1);
      if (c == 20) chk("gap idle", 32'(busy), 32'd0);
      tick();
    end
    start = 1'b0; pixel_valid = 1'b0;
    chk("gap done pulses", 32'(ndone), 32'd1);

    // Saturation: 300 pixels all detected.
    done_at = -1;
    corner_detected2 = 1'b1;
    for (int c = 0; c < 400 && done_at < 0; c++) begin
      start2 = (c == 0);
      pixel_valid2 = (c >= 1);
      @(negedge clk);
      if (done2) done_at = c;
      tick();
    end
    start2 = 1'b0; pixel_valid2 = 1'b0; corner_detected2 = 1'b0;
    chk("sat done cycle", 32'(done_at), 32'd303);
    chk("sat count", 32'(corner_count2), 32'd255);
    chk("sat corner_x", 32'(corner_x2), 32'd0);
    chk("sat corner_y", 32'(corner_y2), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/corner_scan_ctrl.md
CORNER_SCAN_CTRL -- requirements
Module: corner_scan_ctrl

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480, lines per frame.
REQ-003 SHALL have parameter DET_LAT, default 2, cycles from a pixel fed to corner_detect until its corner_detected result (range 1-7).
REQ-004 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port start, input, 1, one-cycle request to scan one frame.
REQ-007 SHALL have port pixel_valid, input, 1, upstream r/g/b presented to corner_detect this cycle.
REQ-008 SHALL have port corner_detected, input, 1, detector result, DET_LAT cycles after its pixel.
REQ-009 SHALL have port det_enable, output, 1, high in SCAN; gates pixel_valid into the detector.
REQ-010 SHALL have ports x and y, output, 10 each, coordinates of the pixel accepted this cycle.
REQ-011 SHALL have ports corner_x and corner_y, output, 10 each, first detection in raster order.
REQ-012 SHALL have port corner_count, output, 8, number of detections this frame.
REQ-013 SHALL have ports busy (1, high in SCAN/DRAIN) and done (1, one-cycle pulse).

Function
REQ-014 SHALL implement FSM IDLE -> SCAN on start; SCAN -> DRAIN after accepting pixel (H_ACTIVE-1, V_ACTIVE-1); DRAIN -> DONE after exactly DET_LAT cycles; DONE -> IDLE after one cycle.
REQ-015 SHALL accept a pixel only when state is SCAN and pixel_valid=1; x increments per accepted pixel, wraps H_ACTIVE-1 -> 0 with y+1.
REQ-016 SHALL carry (x, y, accepted) through a DET_LAT-deep shift register advancing every cycle, including DRAIN.
REQ-017 SHALL count a detection only when corner_detected=1 and the delayed accepted bit is 1; detections with delayed accepted=0 are ignored.
REQ-018 SHALL load corner_x/corner_y with the delayed coordinates on the first counted detection of a frame, hold thereafter.
REQ-019 SHALL saturate corner_count at 255.
REQ-020 SHALL ignore start while busy or in DONE.
REQ-021 SHALL, on an accepted start, clear corner_count to 0, corner_x/corner_y to 10'h3FF, x/y to 0, and the shift register.
REQ-022 SHALL hold all results from DONE until the next accepted start.
REQ-023 SHALL assert done exactly one cycle, in DONE, with results final that cycle.
REQ-024 SHALL tolerate pixel_valid gaps; gaps stall x/y but not DRAIN timing.

Reset
REQ-025 SHALL, with reset=1 at a rising edge, enter IDLE regardless of state, including mid-SCAN/DRAIN.
REQ-026 SHALL reset det_enable, busy, done, x, y, corner_count to 0, corner_x/corner_y to 10'h3FF, and the shift register to 0.
REQ-027 SHALL give reset priority over start in the same cycle.

Configuration
REQ-028 SHALL, with macro CORNER_BBOX_EN defined, add outputs bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax (10 each), updated on every counted detection; cleared to min=10'h3FF, max=0 on reset/start.
REQ-029 SHALL, without CORNER_BBOX_EN, omit those ports and logic; all other behaviour unchanged.

Verification
REQ-030 SHALL cover: H_ACTIVE=4, V_ACTIVE=2, DET_LAT=2, start, 8 back-to-back pixel_valid, corner_detected never -> done 11 cycles after start accepted, corner_count=0, corner_x=corner_y=3FF.
REQ-031 SHALL cover: same, corner_detected high 2 cycles after pixels (1,0) and (2,1) -> corner_count=2, corner_x=1, corner_y=0; with CORNER_BBOX_EN bbox = x 1..2, y 0..1.
REQ-032 SHALL cover: detection on final pixel (3,1) arriving in DRAIN -> counted, corner_count=1, corner_x=3, corner_y=1.
REQ-033 SHALL cover: reset asserted at pixel 5 mid-SCAN -> next cycle IDLE, busy=0, corner_count=0; later start rescans from (0,0).
REQ-034 SHALL cover: start re-pulsed during SCAN and pixel_valid toggling 1/0 -> start ignored, x/y advance only on valid, single done pulse.
REQ-035 SHALL cover: corner_detected held high for 300 accepted pixels (H_ACTIVE=20, V_ACTIVE=15) -> corner_count=255.
